// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and baud helpers.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } uart_tx_state_t;
`endif

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // A 1-clock bit still needs a 1-bit counter to keep the vector legal.
    function automatic int cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter shared by the UART transmitter and receiver.
// Holding restart high parks the counter at zero; bit_done pulses on the last clock of a bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic n_rst,
    input  logic restart,
    output logic bit_done
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q + CW'(1);
        bit_done = 1'b0;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d    = '0;
            bit_done = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, idle-high line; dbg_state exposes the FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic [7:0]     uart_in,
    input  logic           uart_in_valid,
    output logic           tx_ready,
    output logic           serial_out,
    output uart_tx_state_t dbg_state
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 restart;
    logic                 bit_done;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .n_rst    (n_rst),
        .restart  (restart),
        .bit_done (bit_done)
    );

    // Outputs decode straight from registered state so an async reset reaches the line at once.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bit_idx_d  = bit_idx_q;
        restart    = 1'b0;
        serial_out = 1'b1;
        tx_ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_ready = 1'b1;
                restart  = 1'b1;
                if (uart_in_valid) begin
                    data_d    = uart_in;
                    bit_idx_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                serial_out = 1'b0;
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                serial_out = data_q[bit_idx_q];
                if (bit_done) begin
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                serial_out = ^data_q;
                if (bit_done) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                serial_out = 1'b1;
                if (bit_done) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: drivers push sent bytes to exp_q, a line monitor decodes frames and compares.
// Honors UART_TX_PARITY_EN for the 11-bit frame.
`timescale 1ns/1ps
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CLK_FREQ  = 85;   // 85/10 truncates to 8 clocks per bit
  localparam int BAUD_RATE = 10;
  localparam int CPB       = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;
  localparam int TIMEOUT   = 4 * FRAME_CYC;

  // clock / reset
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [7:0] uart_in = 8'h00;
  logic uart_in_valid = 1'b0;
  logic tx_ready;
  logic serial_out;
  uart_tx_state_t dbg_state;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .uart_in       (uart_in),
    .uart_in_valid (uart_in_valid),
    .tx_ready      (tx_ready),
    .serial_out    (serial_out),
    .dbg_state     (dbg_state)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // scoreboard monitor: decodes each frame from the line
  logic in_frame = 1'b0;
  logic check_ready_next = 1'b0;
  logic glitch = 1'b0;
  logic ready_err = 1'b0;
  logic [FRAME_BITS-1:0] frame_bits = '0;
  int cyc = 0;
  int idle_run = 0;
  int last_idle = 0;
  int frames_seen = 0;

  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        in_frame = 1'b0;
        idle_run = 0;
        check_ready_next = 1'b0;
      end else if (!in_frame) begin
        if (check_ready_next) begin
          check("ready_reassert", {31'd0, tx_ready}, 32'd1);
          check_ready_next = 1'b0;
        end
        if (serial_out === 1'b0) begin
          in_frame = 1'b1;
          cyc = 0;
          glitch = 1'b0;
          ready_err = 1'b0;
          last_idle = idle_run;
          idle_run = 0;
        end else begin
          idle_run++;
        end
      end
      if (n_rst && in_frame) begin
        if (cyc % CPB == 0) frame_bits[cyc / CPB] = serial_out;
        else if (serial_out !== frame_bits[cyc / CPB]) glitch = 1'b1;
        if (tx_ready !== 1'b0) ready_err = 1'b1;
        cyc++;
        if (cyc == FRAME_CYC) begin
          in_frame = 1'b0;
          frames_seen++;
          check_ready_next = 1'b1;
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_frame: got data 0x%0h expected no frame", frame_bits[8:1]);
          end else begin
            exp_b = exp_q.pop_front();
            check("frame_data", {24'd0, frame_bits[8:1]}, {24'd0, exp_b});
`ifdef UART_TX_PARITY_EN
            check("frame_parity", {31'd0, frame_bits[9]}, {31'd0, ^exp_b});
`endif
            check("frame_stop", {31'd0, frame_bits[FRAME_BITS-1]}, 32'd1);
            check("bit_stable", {31'd0, glitch}, 32'd0);
            check("ready_low_in_frame", {31'd0, ready_err}, 32'd0);
          end
        end
      end
    end
  end

  // driver tasks (called and returning on a negedge)
  task automatic send(input logic [7:0] b);
    int t = 0;
    while (tx_ready !== 1'b1 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    if (t >= TIMEOUT) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: tx_ready stuck at %b, required 1", tx_ready);
    end
    uart_in = b;
    uart_in_valid = 1'b1;
    exp_q.push_back(b);
    @(negedge clk);
    uart_in_valid = 1'b0;
    check("accept_ready_low", {31'd0, tx_ready}, 32'd0);
    check("accept_start_bit", {31'd0, serial_out}, 32'd0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || in_frame || tx_ready !== 1'b1) && t < 3 * TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3 * TIMEOUT) begin
      tests_run++;
      tests_failed++;
      $display("FAIL idle_timeout: %0d bytes still pending, required 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int t;
    int seen;
    logic [7:0] directed[6];
    directed = '{8'h55, 8'hA5, 8'h01, 8'h80, 8'h07, 8'h03};

    // reset state
    #1;
    check("reset_line", {31'd0, serial_out}, 32'd1);
    check("reset_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // single bytes, including 0x55 and parity vectors 0x07/0x03
    foreach (directed[i]) begin
      send(directed[i]);
      wait_idle();
    end

    // back-to-back with valid held high through the first frame
    send(8'h00);
    uart_in = 8'hFF;
    uart_in_valid = 1'b1;
    exp_q.push_back(8'hFF);
    t = 0;
    while (tx_ready !== 1'b1 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    check("b2b_wait", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    uart_in_valid = 1'b0;
    wait_idle();
    check("b2b_gap", last_idle, 32'd1);

    // busy input: a valid pulse mid-frame must be ignored
    seen = frames_seen;
    send(8'h3C);
    repeat (2 * CPB + 2) @(negedge clk);
    uart_in = 8'hA3;
    uart_in_valid = 1'b1;
    @(negedge clk);
    uart_in_valid = 1'b0;
    check("busy_ready", {31'd0, tx_ready}, 32'd0);
    check("busy_line", {31'd0, serial_out}, 32'd0);   // data bit 1 of 0x3C
    wait_idle();
    repeat (FRAME_CYC) @(negedge clk);
    check("busy_frames", frames_seen, seen + 1);

    // reset during data bit 4 of 0x81
    send(8'h81);
    repeat (5 * CPB + 3) @(negedge clk);
    check("pre_reset_bit4", {31'd0, serial_out}, 32'd0);
    #2 n_rst = 1'b0;
    #1;
    check("abort_line", {31'd0, serial_out}, 32'd1);
    check("abort_ready", {31'd0, tx_ready}, 32'd1);
    check("abort_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    exp_q.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      if (serial_out !== 1'b1) bad++;
    end
    check("idle_after_reset", bad, 32'd0);
    check("ready_after_reset", {31'd0, tx_ready}, 32'd1);

    // accept on the first posedge after reset release
    #2 n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    send(8'h5A);
    wait_idle();

    // loopback-style random bytes
    for (int i = 0; i < 100; i++) begin
      send(8'($urandom_range(0, 255)));
    end
    wait_idle();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
